// File: rtl/stack_control_unit_if.sv
// Control-unit <-> datapath/memory signal bundle for the 16-bit stack processor.
// master: the control unit; slave: the datapath and memory side.
interface stack_control_unit_if;
  logic [5:0]  opcode;
  logic        memory_ready;
  logic        cmd_w;
  logic        R1_w;
  logic        R2_w;
  logic        SR_w;
  logic        PC_w;
  logic        SR_inc;
  logic        PC_inc;
  logic [1:0]  SR_incc;
  logic [1:0]  PC_incc;
  logic [2:0]  ALU_func;
  logic [1:0]  addr_sel;
  logic [1:0]  data_sel;
  logic        memory_w;
  logic        error;
  logic [15:0] addr;

  modport master (
    input  opcode, memory_ready,
    output cmd_w, R1_w, R2_w, SR_w, PC_w, SR_inc, PC_inc, SR_incc, PC_incc,
           ALU_func, addr_sel, data_sel, memory_w, error, addr
  );

  modport slave (
    output opcode, memory_ready,
    input  cmd_w, R1_w, R2_w, SR_w, PC_w, SR_inc, PC_inc, SR_incc, PC_incc,
           ALU_func, addr_sel, data_sel, memory_w, error, addr
  );
endinterface

// File: rtl/stack_control_unit.sv
// Microsequenced control unit: fetch, decode, per-opcode micro-op table, memory token handshake.
// Optional: define CU_ILLEGAL_TRAP_EN to trap illegal opcodes into HALT with a sticky error flag.
module stack_control_unit #(
  parameter int GUARD_CYCLES = 2,
  parameter int SR_PUSH_DIR  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  stack_control_unit_if.master bus
);

  localparam logic [1:0] SEL_PC    = 2'b00;
  localparam logic [1:0] SEL_SR    = 2'b01;
  localparam logic [1:0] SEL_R1    = 2'b10;
  localparam logic [1:0] DS_R1     = 2'b00;
  localparam logic [1:0] DS_ALU    = 2'b10;
  localparam logic [1:0] PUSH_CODE = (SR_PUSH_DIR != 0) ? 2'b01 : 2'b00;
  localparam logic [1:0] POP_CODE  = (SR_PUSH_DIR != 0) ? 2'b00 : 2'b01;
  localparam logic [5:0] OP_HALT   = 6'h06;
  localparam logic [7:0] GUARD_LOAD = (GUARD_CYCLES > 0) ? 8'(GUARD_CYCLES - 1) : 8'd0;

  typedef enum logic [2:0] {
    ST_REQ, ST_GUARD, ST_WAIT, ST_DECODE, ST_SRADJ, ST_PCW, ST_HALT
  } state_t;

  typedef enum logic [1:0] {UK_ACC, UK_SRADJ, UK_PCW, UK_END} ukind_t;

  typedef struct packed {
    ukind_t     kind;
    logic [1:0] sel;
    logic       wr;
    logic [1:0] dsel;
    logic       alu;
    logic       cmd_w;
    logic       r1_w;
    logic       r2_w;
    logic       pc_inc;
    logic       push;
  } uop_t;

  function automatic uop_t u_end();
    uop_t u;
    u = '0;
    u.kind = UK_END;
    return u;
  endfunction

  function automatic uop_t u_rd(logic [1:0] sel, logic r1, logic r2, logic pc_inc);
    uop_t u;
    u = '0;
    u.kind   = UK_ACC;
    u.sel    = sel;
    u.r1_w   = r1;
    u.r2_w   = r2;
    u.pc_inc = pc_inc;
    return u;
  endfunction

  function automatic uop_t u_wr(logic [1:0] dsel, logic alu);
    uop_t u;
    u = '0;
    u.kind = UK_ACC;
    u.sel  = SEL_SR;
    u.wr   = 1'b1;
    u.dsel = dsel;
    u.alu  = alu;
    return u;
  endfunction

  function automatic uop_t u_adj(logic push);
    uop_t u;
    u = '0;
    u.kind = UK_SRADJ;
    u.push = push;
    return u;
  endfunction

  function automatic uop_t u_pcw();
    uop_t u;
    u = '0;
    u.kind = UK_PCW;
    return u;
  endfunction

  // Micro-program: element `step` of the sequence for `op`; UK_END closes the instruction.
  function automatic uop_t uop_at(logic fetch, logic [5:0] op, logic [2:0] step);
    uop_t u;
    u = u_end();
    if (fetch) begin
      u = u_rd(SEL_PC, 1'b0, 1'b0, 1'b1);
      u.cmd_w = 1'b1;
    end else begin
      case (op)
        6'h01: case (step)
          3'd0:    u = u_rd(SEL_PC, 1'b1, 1'b0, 1'b1);
          3'd1:    u = u_adj(1'b1);
          3'd2:    u = u_wr(DS_R1, 1'b0);
          default: u = u_end();
        endcase
        6'h02: case (step)
          3'd0:    u = u_rd(SEL_SR, 1'b1, 1'b0, 1'b0);
          3'd1:    u = u_adj(1'b0);
          default: u = u_end();
        endcase
        6'h03: case (step)
          3'd0:    u = u_rd(SEL_SR, 1'b1, 1'b0, 1'b0);
          3'd1:    u = u_adj(1'b1);
          3'd2:    u = u_wr(DS_R1, 1'b0);
          default: u = u_end();
        endcase
        6'h04: case (step)
          3'd0:    u = u_rd(SEL_SR, 1'b1, 1'b0, 1'b0);
          3'd1:    u = u_adj(1'b0);
          3'd2:    u = u_pcw();
          default: u = u_end();
        endcase
        6'h05: case (step)
          3'd0:    u = u_rd(SEL_SR, 1'b1, 1'b0, 1'b0);
          3'd1:    u = u_rd(SEL_R1, 1'b1, 1'b0, 1'b0);
          3'd2:    u = u_wr(DS_R1, 1'b0);
          default: u = u_end();
        endcase
        6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: case (step)
          3'd0:    u = u_rd(SEL_SR, 1'b0, 1'b1, 1'b0);
          3'd1:    u = u_adj(1'b0);
          3'd2:    u = u_rd(SEL_SR, 1'b1, 1'b0, 1'b0);
          3'd3:    u = u_wr(DS_ALU, 1'b1);
          default: u = u_end();
        endcase
        default: u = u_end();
      endcase
    end
    return u;
  endfunction

  function automatic state_t entry_state(ukind_t k);
    case (k)
      UK_SRADJ: return ST_SRADJ;
      UK_PCW:   return ST_PCW;
      default:  return ST_REQ;
    endcase
  endfunction

`ifdef CU_ILLEGAL_TRAP_EN
  function automatic logic is_legal(logic [5:0] op);
    return ((op[5:3] == 3'b000) && (op != 6'h07)) || (op[5:3] == 3'b001);
  endfunction
`endif

  state_t      state_q, state_n;
  logic        fetch_q, fetch_n;
  logic [2:0]  step_q, step_n;
  logic [5:0]  op_q, op_n;
  logic [7:0]  gcnt_q, gcnt_n;
  logic [15:0] addr_q, addr_n;
  logic        advance;
  uop_t        cur, nxt, dec;
`ifdef CU_ILLEGAL_TRAP_EN
  logic        err_q, err_n;
`endif

  assign cur = uop_at(fetch_q, op_q, step_q);
  assign nxt = uop_at(1'b0, op_q, step_q + 3'd1);
  assign dec = uop_at(1'b0, bus.opcode, 3'd0);
  assign bus.addr = addr_q;
`ifdef CU_ILLEGAL_TRAP_EN
  assign bus.error = err_q;
`else
  assign bus.error = 1'b0;
`endif

  always_comb begin
    state_n = state_q;
    fetch_n = fetch_q;
    step_n  = step_q;
    op_n    = op_q;
    gcnt_n  = gcnt_q;
    addr_n  = addr_q;
    advance = 1'b0;
`ifdef CU_ILLEGAL_TRAP_EN
    err_n   = err_q;
`endif
    bus.cmd_w    = 1'b0;
    bus.R1_w     = 1'b0;
    bus.R2_w     = 1'b0;
    bus.SR_w     = 1'b0;
    bus.PC_w     = 1'b0;
    bus.SR_inc   = 1'b0;
    bus.PC_inc   = 1'b0;
    bus.SR_incc  = 2'b00;
    bus.PC_incc  = 2'b00;
    bus.ALU_func = 3'b000;
    bus.addr_sel = SEL_PC;
    bus.data_sel = DS_R1;
    bus.memory_w = 1'b0;

    // Access selects stay frozen from REQ through WAIT.
    if ((state_q == ST_REQ) || (state_q == ST_GUARD) || (state_q == ST_WAIT)) begin
      bus.addr_sel = (cur.sel == 2'b11) ? SEL_PC : cur.sel;
      bus.data_sel = cur.dsel;
      bus.memory_w = cur.wr;
      bus.ALU_func = cur.alu ? op_q[2:0] : 3'b000;
    end

    case (state_q)
      ST_REQ: begin
        addr_n  = addr_q + 16'd1;
        gcnt_n  = GUARD_LOAD;
        state_n = (GUARD_CYCLES == 0) ? ST_WAIT : ST_GUARD;
      end
      ST_GUARD: begin
        if (gcnt_q == 8'd0) state_n = ST_WAIT;
        else                gcnt_n  = gcnt_q - 8'd1;
      end
      ST_WAIT: begin
        if (bus.memory_ready) begin
          bus.cmd_w  = cur.cmd_w;
          bus.R1_w   = cur.r1_w;
          bus.R2_w   = cur.r2_w;
          bus.PC_inc = cur.pc_inc;
          if (fetch_q) state_n = ST_DECODE;
          else         advance = 1'b1;
        end
      end
      ST_DECODE: begin
        op_n    = bus.opcode;
        fetch_n = 1'b0;
        step_n  = 3'd0;
        if (bus.opcode == OP_HALT) begin
          state_n = ST_HALT;
        end
`ifdef CU_ILLEGAL_TRAP_EN
        else if (!is_legal(bus.opcode)) begin
          err_n   = 1'b1;
          state_n = ST_HALT;
        end
`endif
        else begin
          state_n = entry_state(dec.kind);
          fetch_n = (dec.kind == UK_END);
        end
      end
      ST_SRADJ: begin
        bus.SR_inc  = 1'b1;
        bus.SR_incc = cur.push ? PUSH_CODE : POP_CODE;
        advance     = 1'b1;
      end
      ST_PCW: begin
        bus.PC_w = 1'b1;
        advance  = 1'b1;
      end
      default: ;
    endcase

    // Step to the next micro-op; the end marker rolls straight into the next fetch.
    if (advance) begin
      state_n = entry_state(nxt.kind);
      fetch_n = (nxt.kind == UK_END);
      step_n  = (nxt.kind == UK_END) ? 3'd0 : step_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_REQ;
      fetch_q <= 1'b1;
      step_q  <= 3'd0;
      gcnt_q  <= 8'd0;
      addr_q  <= 16'd0;
    end else begin
      state_q <= state_n;
      fetch_q <= fetch_n;
      step_q  <= step_n;
      gcnt_q  <= gcnt_n;
      addr_q  <= addr_n;
    end
    op_q <= op_n;
  end

`ifdef CU_ILLEGAL_TRAP_EN
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_n;
  end
`endif

endmodule

// File: tb/tb_stack_control_unit.sv
// Directed bench for stack_control_unit: per-opcode vector table plus stall, halt, reset and trap sequences.
module tb_stack_control_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stack_control_unit_if ifc();
  int   mode = 0;          // 0 model, 1 force ready low, 2 force ready high
  logic auto_rdy = 1'b1;
  assign ifc.memory_ready = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : auto_rdy;

  stack_control_unit dut (.clk(clk), .reset(reset), .bus(ifc));

  // Memory: ready drops one edge after a token change, returns 1 (read) or 2 (write) edges later.
  logic [15:0] mem_prev = 16'd0;
  int          age = 100;
  logic        wr_l = 1'b0;
  always @(posedge clk) begin
    #1;
    if (ifc.addr != mem_prev) begin
      age  = 0;
      wr_l = ifc.memory_w;
    end else if (age < 100) begin
      age++;
    end
    mem_prev = ifc.addr;
    auto_rdy = !((age >= 1) && (age < (wr_l ? 3 : 2)));
  end

  typedef struct {
    int cmd, r1, r2, pcinc, pcw, push, pop, wrc, incc_bad, alu_cyc, alu_val;
  } cnt_t;
  cnt_t        c = '{default: 0};
  int          acc_q[$];
  logic [15:0] last_addr = 16'd0;

  always @(negedge clk) begin
    c.cmd      += int'(ifc.cmd_w);
    c.r1       += int'(ifc.R1_w);
    c.r2       += int'(ifc.R2_w);
    c.pcinc    += int'(ifc.PC_inc);
    c.pcw      += int'(ifc.PC_w);
    c.push     += int'(ifc.SR_inc && (ifc.SR_incc == 2'b01));
    c.pop      += int'(ifc.SR_inc && (ifc.SR_incc == 2'b00));
    c.wrc      += int'(ifc.memory_w);
    c.incc_bad += int'(ifc.PC_inc && (ifc.PC_incc != 2'b00));
    if (ifc.ALU_func != 3'b000) begin
      c.alu_cyc++;
      c.alu_val = int'(ifc.ALU_func);
    end
    if (ifc.addr != last_addr)
      acc_q.push_back(32 + 16 * int'(ifc.memory_w) + 4 * int'(ifc.addr_sel) + int'(ifc.data_sel));
    last_addr = ifc.addr;
  end

  typedef struct {
    logic [5:0] op;
    int cyc, dadr, sig, r1, r2, pcinc, push, pop, pcw, alu;
  } vec_t;
  vec_t tbl[$];

  int total = 0;
  int bad   = 0;
  cnt_t base;
  int   i0;
  logic [15:0] a0;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    base = c;
    i0   = acc_q.size();
    a0   = ifc.addr;
  endtask

  function automatic int el(int w, int sel, int ds);
    return 32 + 16 * w + 4 * sel + ds;
  endfunction

  function automatic int fold(int a, int b);
    return a * 64 + b;
  endfunction

  function automatic int sig_since(int start);
    int s = 0;
    for (int k = start; k < acc_q.size(); k++) s = s * 64 + acc_q[k];
    return s;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    run(1);
    reset = 1'b0;
  endtask

  initial begin
    int ef, epc, esr, er1, ewr1, ewalu;
    ef = el(0, 0, 0); epc = el(0, 0, 0); esr = el(0, 1, 0);
    er1 = el(0, 2, 0); ewr1 = el(1, 1, 0); ewalu = el(1, 1, 2);
    //             op     cyc dadr sig                                           r1 r2 pci psh pop pcw alu
    tbl.push_back('{6'h00,  5, 1, ef,                                            0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{6'h01, 15, 3, fold(fold(ef, epc), ewr1),                     1, 0, 2, 1, 0, 0, 0});
    tbl.push_back('{6'h02, 10, 2, fold(ef, esr),                                 1, 0, 1, 0, 1, 0, 0});
    tbl.push_back('{6'h03, 15, 3, fold(fold(ef, esr), ewr1),                     1, 0, 1, 1, 0, 0, 0});
    tbl.push_back('{6'h04, 11, 2, fold(ef, esr),                                 1, 0, 1, 0, 1, 1, 0});
    tbl.push_back('{6'h05, 18, 4, fold(fold(fold(ef, esr), er1), ewr1),         1 + 1, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{6'h0B, 19, 4, fold(fold(fold(ef, esr), esr), ewalu),        1, 1, 1, 0, 1, 0, 3});
    tbl.push_back('{6'h0E, 19, 4, fold(fold(fold(ef, esr), esr), ewalu),        1, 1, 1, 0, 1, 0, 6});
`ifndef CU_ILLEGAL_TRAP_EN
    tbl.push_back('{6'h3F,  5, 1, ef,                                            0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{6'h07,  5, 1, ef,                                            0, 0, 1, 0, 0, 0, 0});
`endif

    ifc.opcode = 6'h00;
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    chk("rst_addr", int'(ifc.addr), 0);
    chk("rst_error", int'(ifc.error), 0);
    chk("rst_memw", int'(ifc.memory_w), 0);
    chk("rst_strobes", int'({ifc.cmd_w, ifc.R1_w, ifc.R2_w, ifc.SR_w, ifc.PC_w, ifc.SR_inc, ifc.PC_inc}), 0);
    chk("rst_sels", int'({ifc.addr_sel, ifc.data_sel, ifc.ALU_func}), 0);

    // NOP stream: one token per 5-cycle fetch/decode.
    snap();
    run(20);
    chk("nop_addr", int'(ifc.addr), 4);
    chk("nop_cmd_w", c.cmd - base.cmd, 4);
    chk("nop_pc_inc", c.pcinc - base.pcinc, 4);
    chk("nop_memw", c.wrc - base.wrc, 0);

    foreach (tbl[i]) begin
      ifc.opcode = tbl[i].op;
      snap();
      run(tbl[i].cyc);
      chk($sformatf("op%02h_addr", tbl[i].op), int'(ifc.addr - a0), tbl[i].dadr);
      chk($sformatf("op%02h_access_sig", tbl[i].op), sig_since(i0), tbl[i].sig);
      chk($sformatf("op%02h_cmd_w", tbl[i].op), c.cmd - base.cmd, 1);
      chk($sformatf("op%02h_R1_w", tbl[i].op), c.r1 - base.r1, tbl[i].r1);
      chk($sformatf("op%02h_R2_w", tbl[i].op), c.r2 - base.r2, tbl[i].r2);
      chk($sformatf("op%02h_PC_inc", tbl[i].op), c.pcinc - base.pcinc, tbl[i].pcinc);
      chk($sformatf("op%02h_SR_push", tbl[i].op), c.push - base.push, tbl[i].push);
      chk($sformatf("op%02h_SR_pop", tbl[i].op), c.pop - base.pop, tbl[i].pop);
      chk($sformatf("op%02h_PC_w", tbl[i].op), c.pcw - base.pcw, tbl[i].pcw);
      chk($sformatf("op%02h_alu_cycles", tbl[i].op), c.alu_cyc - base.alu_cyc, (tbl[i].alu != 0) ? 5 : 0);
      if (tbl[i].alu != 0)
        chk($sformatf("op%02h_alu_func", tbl[i].op), c.alu_val, tbl[i].alu);
      chk($sformatf("op%02h_pc_incc", tbl[i].op), c.incc_bad - base.incc_bad, 0);
      chk($sformatf("op%02h_error", tbl[i].op), int'(ifc.error), 0);
    end

    // Ready held low: fetch parks in WAIT; releasing ready completes on that same cycle.
    ifc.opcode = 6'h00;
    mode = 1;
    snap();
    run(12);
    chk("stall_addr", int'(ifc.addr - a0), 1);
    chk("stall_cmd_w", c.cmd - base.cmd, 0);
    mode = 2;
    @(negedge clk);
    chk("release_cmd_w", int'(ifc.cmd_w), 1);
    chk("release_pc_inc", int'(ifc.PC_inc), 1);
    @(posedge clk);
    #1;
    mode = 0;
    chk("release_decode_cmd_w", int'(ifc.cmd_w), 0);
    run(1);
    chk("release_addr", int'(ifc.addr - a0), 1);

    // HALT: no further tokens or strobes until reset.
    ifc.opcode = 6'h06;
    snap();
    run(15);
    chk("halt_addr", int'(ifc.addr - a0), 1);
    chk("halt_cmd_w", c.cmd - base.cmd, 1);
    chk("halt_other", (c.r1 - base.r1) + (c.r2 - base.r2) + (c.push - base.push) + (c.pop - base.pop)
                      + (c.pcw - base.pcw) + (c.wrc - base.wrc), 0);
    ifc.opcode = 6'h00;
    do_reset();
    chk("halt_rst_addr", int'(ifc.addr), 0);
    run(5);
    chk("halt_resume_addr", int'(ifc.addr), 1);

    // Reset in G2 of the PUSHI write abandons the access.
    ifc.opcode = 6'h01;
    run(12);
    chk("g2_memw", int'(ifc.memory_w), 1);
    chk("g2_addr_sel", int'(ifc.addr_sel), 1);
    chk("g2_addr", int'(ifc.addr), 4);
    ifc.opcode = 6'h00;
    do_reset();
    chk("g2rst_addr", int'(ifc.addr), 0);
    chk("g2rst_memw", int'(ifc.memory_w), 0);
    chk("g2rst_addr_sel", int'(ifc.addr_sel), 0);
    snap();
    run(5);
    chk("g2rst_fetch_addr", int'(ifc.addr), 1);
    chk("g2rst_fetch_cmd_w", c.cmd - base.cmd, 1);

`ifdef CU_ILLEGAL_TRAP_EN
    // Illegal opcode traps: error rises after DECODE, tokens freeze, reset recovers.
    ifc.opcode = 6'h3F;
    snap();
    run(4);
    chk("trap_pre_error", int'(ifc.error), 0);
    run(1);
    chk("trap_error", int'(ifc.error), 1);
    run(10);
    chk("trap_addr", int'(ifc.addr - a0), 1);
    chk("trap_error_sticky", int'(ifc.error), 1);
    ifc.opcode = 6'h00;
    do_reset();
    chk("trap_rst_error", int'(ifc.error), 0);
    chk("trap_rst_addr", int'(ifc.addr), 0);
    run(5);
    chk("trap_resume_addr", int'(ifc.addr), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
